// File: rtl/demux_1by4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready buffer per channel.
// Define DEMUX_CNT_EN to add four 8-bit wrapping delivery counters on cnt_flat.
module demux_1by4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [1:0]       sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             busy
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]      cnt_flat
`endif
);

  logic [WIDTH-1:0] r_data [4];
  logic [3:0]       r_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic [3:0]       w_load;
  logic [3:0]       w_deliver;

  // The selected slot can take a word if it is empty or is being drained this cycle.
  assign w_in_ready = !r_valid[sel] || out_ready[sel];
  assign w_accept   = in_valid && w_in_ready;
  assign w_load     = {4{w_accept}} & (4'b0001 << sel);
  assign w_deliver  = r_valid & out_ready;

  // A load wins over a delivery on the same channel so back-to-back words never bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= '0;
      end
      r_valid <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) begin
          r_data[i]  <= in_data;
          r_valid[i] <= 1'b1;
        end else if (w_deliver[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out0      = r_data[0];
  assign out1      = r_data[1];
  assign out2      = r_data[2];
  assign out3      = r_data[3];
  assign out_valid = r_valid;
  assign busy      = |r_valid;

`ifdef DEMUX_CNT_EN
  logic [7:0] r_cnt [4];

  // Counters wrap naturally at 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_deliver[i]) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign cnt_flat = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule
